// File: rtl/instruction_sequencer_if.sv
// Shared memory-bus handshake between the instruction sequencer (master)
// and the memory system (slave).
interface instruction_sequencer_if;
   logic mem_valid;
   logic mem_fetch;
   logic mem_write;
   logic mem_ready;

   modport master (
      output mem_valid,
      output mem_fetch,
      output mem_write,
      input  mem_ready
   );

   modport slave (
      input  mem_valid,
      input  mem_fetch,
      input  mem_write,
      output mem_ready
   );
endinterface

// File: rtl/instruction_sequencer.sv
// Multi-cycle control FSM: fetch/decode/execute/memory/writeback sequencing,
// next-PC selection, interrupt/trap arbitration, retire counting and memory timeout.
package instruction_sequencer_pkg;
   typedef struct packed {
      logic is_load;
      logic is_store;
      logic is_jump;
      logic is_branch;
      logic is_trap;
      logic is_mret;
      logic has_rd;
   } instruction_t;
endpackage

module instruction_sequencer
   import instruction_sequencer_pkg::*;
#(
   parameter int MEM_TIMEOUT   = 0,
   parameter int INSTRET_WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     reset_n,
   instruction_sequencer_if.master  bus,
   input  instruction_t             instr,
   input  logic                     branch_taken,
   input  logic                     irq,
   input  logic                     irq_enable,
   output logic [2:0]               state,
   output logic                     fetch_en,
   output logic                     decode_en,
   output logic                     execute_en,
   output logic                     load_en,
   output logic                     writeback_en,
   output logic                     pc_en,
   output logic [1:0]               pc_sel,
   output logic                     trap_save,
   output logic                     irq_taken,
   output logic                     bus_error,
   output logic                     retired,
   output logic [INSTRET_WIDTH-1:0] instret
);

   // FAULT is the writeback slot of a timed-out access; externally it reads as WRITEBACK.
   typedef enum logic [2:0] {
      FETCH     = 3'd0,
      DECODE    = 3'd1,
      EXECUTE   = 3'd2,
      LOAD      = 3'd3,
      STORE     = 3'd4,
      WRITEBACK = 3'd5,
      FAULT     = 3'd6
   } state_t;

   localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT);

   state_t        cur;
   logic [CW-1:0] wait_count;
   logic          in_mem;
   logic          timed_out;

   assign in_mem    = (cur == FETCH) || (cur == LOAD) || (cur == STORE);
   assign timed_out = (MEM_TIMEOUT > 0) && in_mem && !bus.mem_ready && (wait_count == LIMIT);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cur        <= FETCH;
         wait_count <= '0;
         instret    <= '0;
      end else begin
         if (retired)
            instret <= instret + 1'b1;

         // Leaving a memory state always clears the counter, so every entry starts at zero.
         if ((MEM_TIMEOUT > 0) && in_mem && !bus.mem_ready && !timed_out)
            wait_count <= wait_count + 1'b1;
         else
            wait_count <= '0;

         case (cur)
            FETCH: begin
               if (timed_out)          cur <= FAULT;
               else if (bus.mem_ready) cur <= DECODE;
            end
            DECODE:  cur <= EXECUTE;
            EXECUTE: begin
               if (instr.is_load)       cur <= LOAD;
               else if (instr.is_store) cur <= STORE;
               else                     cur <= WRITEBACK;
            end
            LOAD, STORE: begin
               if (timed_out)          cur <= FAULT;
               else if (bus.mem_ready) cur <= WRITEBACK;
            end
            WRITEBACK, FAULT: cur <= FETCH;
            default:          cur <= FETCH;
         endcase
      end
   end

   always_comb begin
      state         = 3'd0;
      bus.mem_valid = 1'b0;
      bus.mem_fetch = 1'b0;
      bus.mem_write = 1'b0;
      fetch_en      = 1'b0;
      decode_en     = 1'b0;
      execute_en    = 1'b0;
      load_en       = 1'b0;
      writeback_en  = 1'b0;
      pc_en         = 1'b0;
      pc_sel        = 2'd0;
      trap_save     = 1'b0;
      irq_taken     = 1'b0;
      bus_error     = 1'b0;
      retired       = 1'b0;
      if (reset_n) begin
         state     = (cur == FAULT) ? 3'(WRITEBACK) : 3'(cur);
         bus_error = timed_out;
         case (cur)
            FETCH: begin
               bus.mem_valid = 1'b1;
               bus.mem_fetch = 1'b1;
               fetch_en      = bus.mem_ready;
            end
            DECODE:  decode_en  = 1'b1;
            EXECUTE: execute_en = 1'b1;
            LOAD: begin
               bus.mem_valid = 1'b1;
               load_en       = bus.mem_ready;
            end
            STORE: begin
               bus.mem_valid = 1'b1;
               bus.mem_write = 1'b1;
            end
            WRITEBACK: begin
               pc_en        = 1'b1;
               retired      = 1'b1;
               writeback_en = instr.has_rd;
               if (irq && irq_enable) begin
                  pc_sel    = 2'd2;
                  irq_taken = 1'b1;
                  trap_save = 1'b1;
               end else if (instr.is_trap) begin
                  pc_sel    = 2'd2;
                  trap_save = 1'b1;
               end else if (instr.is_mret) begin
                  pc_sel = 2'd3;
               end else if (instr.is_jump || (instr.is_branch && branch_taken)) begin
                  pc_sel = 2'd1;
               end
            end
            FAULT: begin
               pc_en     = 1'b1;
               pc_sel    = 2'd2;
               trap_save = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/instruction_sequencer.md
Name: instruction_sequencer

Overview:
- Multi-cycle control FSM for the core. It sequences fetch, decode, execute, memory access and writeback around the instruction decoder, ALU and register file.
- It drives the shared memory bus handshake, selects the next-PC source, and arbitrates interrupts, traps and mret at instruction boundaries.
- It also maintains the retired-instruction counter and a memory-wait timeout.

Parameters:
- MEM_TIMEOUT, 0, maximum wait cycles for mem_ready in any memory state; 0 disables the timeout.
- INSTRET_WIDTH, 32, width of the instret counter.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- instr  in  instruction_t  decoded fields of the current instruction register, combinational from the decoder.
- branch_taken  in  1  branch condition from the comparator; valid in WRITEBACK.
- irq  in  1  interrupt request, level-sensitive.
- irq_enable  in  1  global interrupt enable (mstatus.MIE).
- mem_ready  in  1  memory acknowledges the current access.
- state  out  3  FETCH=0, DECODE=1, EXECUTE=2, LOAD=3, STORE=4, WRITEBACK=5.
- mem_valid  out  1  memory request active.
- mem_fetch  out  1  request is an instruction fetch.
- mem_write  out  1  request is a store.
- fetch_en  out  1  load the instruction register.
- decode_en  out  1  latch register-file operands.
- execute_en  out  1  latch the ALU result.
- load_en  out  1  latch load data.
- writeback_en  out  1  register-file write.
- pc_en  out  1  update PC.
- pc_sel  out  2  next-PC source: 0=PC+4, 1=target, 2=trap vector, 3=mepc.
- trap_save  out  1  save mepc/mcause.
- irq_taken  out  1  interrupt accepted.
- bus_error  out  1  memory timeout occurred.
- retired  out  1  instruction retired this cycle.
- instret  out  INSTRET_WIDTH  retired-instruction count.

Behaviour:
- Reset
  - The state register and instret are asynchronously cleared: state=FETCH, instret=0.
  - While reset_n=0, every other output is forced to 0, including mem_valid.
  - The first request is issued in the first cycle after reset_n rises.
  - Reset asserted mid-access abandons the access with no retire and no writeback.
- Outputs are combinational from state and inputs; only the state register, the wait counter and instret are registered.
- FETCH
  - mem_valid=1, mem_fetch=1.
  - Hold until mem_ready; in the mem_ready cycle fetch_en=1, then go to DECODE.
- DECODE
  - decode_en=1, then go to EXECUTE. Always exactly 1 cycle.
- EXECUTE
  - execute_en=1.
  - Next state: is_load -> LOAD, else is_store -> STORE, else WRITEBACK.
- LOAD
  - mem_valid=1.
  - On mem_ready, load_en=1 and go to WRITEBACK.
- STORE
  - mem_valid=1, mem_write=1.
  - On mem_ready, go to WRITEBACK.
- WRITEBACK
  - Always exactly 1 cycle; pc_en=1, next state FETCH.
  - writeback_en=instr.has_rd.
  - retired=1.
  - pc_sel priority:
    1. irq && irq_enable -> 2, with irq_taken=1 and trap_save=1.
    2. is_trap -> 2, with trap_save=1.
    3. is_mret -> 3.
    4. is_jump, or is_branch && branch_taken -> 1.
    5. Otherwise -> 0.
  - An accepted interrupt does not suppress writeback of the current instruction. mepc receives the would-be next PC, which is the datapath's duty.
- Interrupt sampling
  - irq is sampled only in WRITEBACK.
  - irq asserted in any other state has no effect until WRITEBACK.
  - irq with irq_enable=0 is ignored.
- mem_ready outside FETCH/LOAD/STORE is ignored.
- Timeout (MEM_TIMEOUT>0)
  - The wait counter clears on entry to every memory state and increments each cycle mem_ready=0 in that state.
  - When the counter reaches MEM_TIMEOUT without mem_ready:
    - bus_error=1 for one cycle.
    - Go to WRITEBACK with a forced trap: pc_sel=2, trap_save=1, writeback_en=0, retired=0, and fetch_en/load_en suppressed.
  - mem_ready in the same cycle the counter reaches MEM_TIMEOUT wins: there is no error.
- instret
  - Increments by 1 on each retired=1 cycle.
  - Wraps from all-ones to 0 silently.
- Latency with zero-wait memory (mem_ready=1 in the request cycle):
  - ALU, jump, branch and system instructions: 4 cycles.
  - Loads and stores: 5 cycles.
  - Each memory wait cycle adds 1.

Test Plan:
- Reset, then ADD x1,x2,x3 with mem_ready tied 1:
  - state sequence 0,1,2,5,0.
  - writeback_en=1 and pc_sel=0 in cycle 4; instret=1 after 4 cycles.
- LW with mem_ready held low 3 cycles in LOAD:
  - state stays 3 for 4 cycles; load_en pulses once; writeback in the next cycle; total 8 cycles.
- SW then BEQ with branch_taken=1:
  - SW gives mem_write=1 only in STORE, writeback_en=0, pc_sel=0.
  - BEQ gives pc_sel=1, writeback_en=0.
- ECALL with irq=1 and irq_enable=1 in WRITEBACK:
  - pc_sel=2, irq_taken=1, trap_save=1.
  - With irq_enable=0: pc_sel=2 (trap) and irq_taken=0.
- MEM_TIMEOUT=4, FETCH with mem_ready never asserted:
  - bus_error=1 in the 5th FETCH cycle; next cycle is WRITEBACK with pc_sel=2, retired=0; instret unchanged.
- Edge cases:
  - Assert reset_n=0 mid-LOAD: mem_valid drops immediately, state=0, instret=0.
  - instret preloaded to 0xFFFFFFFF via force, then one retire -> 0x00000000.
